key_led_ctrl: RTL and testbench

Push-button LED mode controller for the single-key / single-LED board path. It synchronises and debounces the raw `key_in` level and turns each clean press into a one-cycle event. That event steps a four-state mode machine (off, on, slow blink, fast blink), and the machine drives the registered `led` output. It replaces the direct key-to-LED flip-flop path, and the toggle-flip-flop testbench style (50 MHz `sys_clk`, random `key_in`) carries over.

---
 rtl/key_led_ctrl.sv | 85 ++++++++
 tb/tb_key_led_ctrl.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/key_led_ctrl.sv
// key_led_ctrl: debounced push-button stepping an off/on/slow/fast LED mode machine
module key_led_ctrl #(
   parameter int CNT_DEBOUNCE = 1_000_000,
   parameter int CNT_SLOW     = 25_000_000,
   parameter int CNT_FAST     = 5_000_000
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       key_in,
   output logic       led,
   output logic [1:0] mode,
   output logic       key_flag
);
   localparam int DW = $clog2(CNT_DEBOUNCE);
   localparam int BW = $clog2(CNT_SLOW);

   typedef enum logic [1:0] {OFF = 2'b00, ON = 2'b01, SLOW = 2'b10, FAST = 2'b11} mode_t;

   logic          key_s1, key_s2;
   logic [DW-1:0] cnt_db;
   logic [BW-1:0] cnt_bl, bl_max;
   logic          ph;
   mode_t         state, state_nx;

   assign mode   = state;
   assign bl_max = (state == FAST) ? BW'(CNT_FAST - 1) : BW'(CNT_SLOW - 1);

   // two-flop synchroniser; idles high so a released key never looks pressed
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
      end else begin
         key_s1 <= key_in;
         key_s2 <= key_s1;
      end
   end

   // saturating low-time counter; the flag fires only on the step into saturation
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_db   <= '0;
         key_flag <= 1'b0;
      end else begin
         key_flag <= ~key_s2 & (cnt_db == DW'(CNT_DEBOUNCE - 2));
         if (key_s2) cnt_db <= '0;
         else if (cnt_db != DW'(CNT_DEBOUNCE - 1)) cnt_db <= cnt_db + 1'b1;
      end
   end

   // mode register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state <= OFF;
      else state <= state_nx;
   end

   // each accepted press steps to the next mode, wrapping FAST back to OFF
   always_comb begin
      state_nx = state;
      if (key_flag) state_nx = mode_t'(state + 2'd1);
   end

   // blink timer; a mode change restarts the phase high and overrides any wrap
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_bl <= '0;
         ph     <= 1'b0;
      end else if (key_flag) begin
         cnt_bl <= '0;
         ph     <= state_nx[1];
      end else if (state[1]) begin
         cnt_bl <= (cnt_bl == bl_max) ? '0 : cnt_bl + 1'b1;
         ph     <= (cnt_bl == bl_max) ? ~ph : ph;
      end else begin
         cnt_bl <= '0;
         ph     <= 1'b0;
      end
   end

   // registered LED drive: dark, lit, or following the blink phase
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) led <= 1'b0;
      else led <= (state == ON) | (state[1] & ph);
   end
endmodule

// File: tb/tb_key_led_ctrl.sv
// tb_key_led_ctrl: scoreboard bench for the debounced LED mode controller
module tb_key_led_ctrl;
   localparam int D = 20;
   localparam int S = 10;
   localparam int F = 4;

   typedef struct {
      int         cyc;
      logic [1:0] mode;
   } ev_t;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       key_in;
   logic       led;
   logic [1:0] mode;
   logic       key_flag;

   int         cyc = 0;
   int         errs = 0;
   int         checks = 0;
   int         run = 0;
   int         last_push = 0;
   logic [1:0] m_model = 2'b00;
   ev_t        q[$];

   key_led_ctrl #(.CNT_DEBOUNCE(D), .CNT_SLOW(S), .CNT_FAST(F)) dut (
      .sys_clk(sys_clk),
      .sys_rst_n(sys_rst_n),
      .key_in(key_in),
      .led(led),
      .mode(mode),
      .key_flag(key_flag)
   );

   always #10 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   // drive one key sample just after an edge; a low run reaching D-1 samples
   // produces a flag D+1 cycles after its first drive, i.e. 3 after this one
   task automatic drive(input logic v);
      @(posedge sys_clk);
      #1;
      key_in = v;
      if (v) run = 0;
      else begin
         run++;
         if (run == D - 1) begin
            m_model = m_model + 2'd1;
            last_push = cyc + 3;
            q.push_back('{cyc: cyc + 3, mode: m_model});
         end
      end
   endtask

   task automatic press(input int lo, input int hi);
      repeat (lo) drive(1'b0);
      repeat (hi) drive(1'b1);
   endtask

   // monitor: every flag pops one expected event and checks what follows it
   initial begin
      ev_t e;
      int  half;
      forever begin
         @(negedge sys_clk);
         if (sys_rst_n && key_flag) begin
            if (q.size() == 0) begin
               errs++;
               checks++;
               $display("FAIL unexpected_flag cyc=%0d actual=1 expected=0", cyc);
            end else begin
               e = q.pop_front();
               check("flag_cycle", cyc, e.cyc);
               @(negedge sys_clk);
               check("flag_width", int'(key_flag), 0);
               check("mode_step", int'(mode), int'(e.mode));
               @(negedge sys_clk);
               check("led_entry", int'(led), int'(e.mode != 2'b00));
               half = (e.mode == 2'b11) ? F : S;
               if (e.mode[1]) begin
                  for (int j = 1; j < 3 * half; j++) begin
                     @(negedge sys_clk);
                     if (!sys_rst_n) break;
                     check("led_blink", int'(led), int'(((j / half) % 2) == 0));
                  end
               end
            end
         end
      end
   end

   initial begin
      sys_rst_n = 1'b0;
      key_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #9;
         check("rst_led", int'(led), 0);
         check("rst_mode", int'(mode), 0);
         check("rst_flag", int'(key_flag), 0);
         #1;
      end
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      repeat (10) begin
         repeat (5) drive(1'b0);
         repeat (3) drive(1'b1);
      end
      repeat (20) drive(1'b1);
      check("bounce_mode", int'(mode), 0);
      press(60, 50);
      check("press_mode", int'(mode), 1);
      check("press_led", int'(led), 1);
      press(30, 50);
      check("cycle_slow", int'(mode), 2);
      press(30, 50);
      check("cycle_fast", int'(mode), 3);
      press(30, 50);
      check("cycle_off", int'(mode), 0);
      check("cycle_off_led", int'(led), 0);
      press(30, 50);
      repeat (20) drive(1'b0);
      while (cyc < last_push + 6) drive(1'b0);
      check("pre_rst_mode", int'(mode), 2);
      sys_rst_n = 1'b0;
      m_model = 2'b00;
      run = 0;
      #1;
      check("midrst_mode", int'(mode), 0);
      check("midrst_led", int'(led), 0);
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      run = 1;
      repeat (25) drive(1'b0);
      repeat (30) drive(1'b1);
      check("post_rst_mode", int'(mode), 1);
      repeat (2000) drive(1'($urandom_range(0, 1)));
      repeat (60) drive(1'b1);
      check("final_mode", int'(mode), int'(m_model));
      check("queue_empty", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
